// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one bitwise logic unit (AND/OR/NOR/XOR)
// among N_REQ requesters. Define LU_FAST_RESP_EN to drop EXEC and respond on the grant edge.
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   busy
);

    // state | meaning
    // IDLE  | arbitrating; req_ready one-hot on the round-robin winner
    // EXEC  | computing op(a,b) from the latched request (absent in fast build)
    // RESP  | rsp_valid high, outputs held until rsp_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       last_grant;

    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       win_op;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;

`ifndef LU_FAST_RESP_EN
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       idx_q;
`endif

    function automatic logic [WIDTH-1:0] lu_eval(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00: r = a & b;
            2'b01: r = a | b;
            2'b10: r = ~(a | b);
            2'b11: r = a ^ b;
        endcase
        return r;
    endfunction

    // Search starts one past the last granted index so the previous owner goes last.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_grant) + k) % N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if (!win_found && cand == i && req_valid[i]) begin
                    win_found = 1'b1;
                    win_idx   = 2'(i);
                end
            end
        end
    end

    always_comb begin
        win_op = '0;
        win_a  = '0;
        win_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == 2'(i)) begin
                win_op = req_op[2*i +: 2];
                win_a  = req_a[WIDTH*i +: WIDTH];
                win_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (state == IDLE) && win_found && (win_idx == 2'(i));
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 2'(N_REQ - 1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
`ifndef LU_FAST_RESP_EN
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            idx_q      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
`ifdef LU_FAST_RESP_EN
                        rsp_data  <= lu_eval(win_op, win_a, win_b);
                        rsp_id    <= win_idx;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`else
                        op_q  <= win_op;
                        a_q   <= win_a;
                        b_q   <= win_b;
                        idx_q <= win_idx;
                        state <= EXEC;
`endif
                    end
                end
`ifndef LU_FAST_RESP_EN
                EXEC: begin
                    rsp_data  <= lu_eval(op_q, a_q, b_q);
                    rsp_id    <= idx_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= rsp_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter; expected values are hand-computed constants.
// Latency expectations follow LU_FAST_RESP_EN when the bench is built with it.
module tb_logic_unit_arbiter;

`ifdef LU_FAST_RESP_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [7:0]   req_op;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         busy;

    logic [1:0]   op_arr [4];
    logic [31:0]  a_arr  [4];
    logic [31:0]  b_arr  [4];

    assign req_op = {op_arr[3], op_arr[2], op_arr[1], op_arr[0]};
    assign req_a  = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign req_b  = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic_unit_arbiter #(.N_REQ(4), .WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] idx, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        op_arr[idx]    = op;
        a_arr[idx]     = a;
        b_arr[idx]     = b;
        req_valid[idx] = 1'b1;
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (req_ready == 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        check_eq("grant_wait", 64'(req_ready != 4'b0000), 64'd1);
    endtask

    // Called at the grant cycle; drops the request, checks latency, stalls, handshakes.
    task automatic finish_rsp(input logic [1:0] idx, input logic [31:0] exp, input int n_stall);
        int t0;
        t0 = cyc;
        tick();
        req_valid[idx] = 1'b0;
        #1;
        check_eq("ready_after_grant", 64'(req_ready), 64'd0);
        check_eq("busy_after_grant", 64'(busy), 64'd1);
        for (int i = 1; i < LAT; i++) begin
            check_eq("exec_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
        check_eq("latency", 64'(cyc - t0), 64'(LAT));
        for (int s = 0; s <= n_stall; s++) begin
            check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
            check_eq("rsp_id", 64'(rsp_id), 64'(idx));
            check_eq("rsp_data", 64'(rsp_data), 64'(exp));
            check_eq("ready_in_resp", 64'(req_ready), 64'd0);
            if (s < n_stall) tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("rsp_cleared", 64'(rsp_valid), 64'd0);
        check_eq("busy_cleared", 64'(busy), 64'd0);
        check_eq("rsp_data_held", 64'(rsp_data), 64'(exp));
    endtask

    task automatic do_single(input logic [1:0] idx, input logic [1:0] op,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        set_req(idx, op, a, b);
        #1;
        wait_grant();
        check_eq("single_grant", 64'(req_ready), 64'(4'b0001 << idx));
        finish_rsp(idx, exp, 0);
    endtask

    logic [31:0] rr_exp [4];
    int          last_t;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op_arr[i] = '0;
            a_arr[i]  = '0;
            b_arr[i]  = '0;
        end
        rr_exp[0] = 32'hF000_F000;
        rr_exp[1] = 32'hFFF0_FFF0;
        rr_exp[2] = 32'h000F_000F;
        rr_exp[3] = 32'h0FF0_0FF0;
        last_t    = 0;

        #12;
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_id", 64'(rsp_id), 64'd0);
        check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Round-robin from reset: requester i uses op i on the same operands.
        for (int i = 0; i < 4; i++)
            set_req(2'(i), 2'(i), 32'hF0F0_F0F0, 32'hFF00_FF00);
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            wait_grant();
            check_eq("rr_grant", 64'(req_ready), 64'(4'b0001 << (g % 4)));
            if (g > 0) check_eq("rr_spacing", 64'(cyc - last_t), 64'(LAT + 1));
            last_t = cyc;
            for (int i = 0; i < LAT; i++) tick();
            check_eq("rr_rsp_valid", 64'(rsp_valid), 64'd1);
            check_eq("rr_rsp_id", 64'(rsp_id), 64'(g % 4));
            check_eq("rr_rsp_data", 64'(rsp_data), 64'(rr_exp[g % 4]));
            if (g == 4) req_valid = '0;
            tick();
        end
        rsp_ready = 1'b0;
        check_eq("rr_idle", 64'(busy), 64'd0);

        do_single(2'd1, 2'b10, 32'h0000_FFFF, 32'h00FF_00FF, 32'hFF00_0000);
        do_single(2'd0, 2'b10, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);

        // Backpressure: 2 wins over 3 after last grant 0; 3 stays valid throughout the stall.
        set_req(2'd2, 2'b00, 32'hFFFF_0000, 32'h1234_5678);
        set_req(2'd3, 2'b11, 32'h1234_5678, 32'hFFFF_0000);
        #1;
        wait_grant();
        check_eq("bp_grant2", 64'(req_ready), 64'b0100);
        finish_rsp(2'd2, 32'h1234_0000, 5);
        check_eq("bp_grant3", 64'(req_ready), 64'b1000);
        finish_rsp(2'd3, 32'hEDCB_5678, 0);

        // Asynchronous reset while a response is pending.
        set_req(2'd1, 2'b01, 32'h0000_0001, 32'h0000_0002);
        #1;
        wait_grant();
        tick();
        req_valid = '0;
        repeat (LAT - 1) tick();
        check_eq("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("arst_req_ready", 64'(req_ready), 64'd0);
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_rsp_data", 64'(rsp_data), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
        do_single(2'd2, 2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
